pattern_detector: RTL and testbench
===================================

PATTERN_DETECTOR -- requirements
Module: pattern_detector

Interface
REQ-001 Parameter MAX_LEN, default 8, maximum pattern length in bits (legal range 2..16).
REQ-002 Parameter RESET_LEN, default 2, pattern length loaded at reset.
REQ-003 Parameter RESET_PATTERN, default 'b01, pattern loaded at reset; bit [len-1] is the first-received bit and bit 0 the last.
REQ-004 Parameter RESET_OVERLAP, default 1, overlap mode loaded at reset.
REQ-005 Port clk, input, 1, single clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1, reset, asynchronous, active-high.
REQ-007 Port in_valid, input, 1, A is sampled only when 1.
REQ-008 Port A, input, 1, serial data bit.
REQ-009 Port cfg_load, input, 1, loads the configuration inputs on this edge.
REQ-010 Port cfg_pattern, input, MAX_LEN, new pattern (LSB-aligned).
REQ-011 Port cfg_len, input, LW = $clog2(MAX_LEN+1), new pattern length.
REQ-012 Port cfg_overlap, input, 1, 1 = overlapping matches, 0 = non-overlapping.
REQ-013 Port cnt_clr, input, 1, synchronous clear of match_count.
REQ-014 Port Y, output, 1, registered match pulse.
REQ-015 Port match_count, output, 16, number of matches.

Function
REQ-016 The window shall shift on each edge with in_valid=1: hist <= {hist[MAX_LEN-2:0], A}.
REQ-017 Counter fill shall increment on each sampled bit and saturate at MAX_LEN.
REQ-018 A match shall occur on an edge with in_valid=1 when the low len bits of the updated hist equal the low len bits of the pattern and the updated fill >= len.
REQ-019 Y shall be 1 for exactly the one cycle following a matching edge (Moore-style, registered), and 0 otherwise, including in every cycle that follows an edge with in_valid=0.
REQ-020 Overlap mode: fill is unaffected by a match, so "0101" with pattern "01" and len 2 yields 2 matches, and "111" with pattern "11" yields 2 matches.
REQ-021 Non-overlap mode: fill shall clear to 0 on a match edge, so "111" with pattern "11" yields 1 match.
REQ-022 cfg_load=1 shall, on that edge, load pattern, len and overlap and clear hist, fill and Y.
REQ-023 When cfg_load=1, any in_valid on the same edge shall be ignored.
REQ-024 cfg_len=0 shall be treated as 1, and cfg_len>MAX_LEN shall be clamped to MAX_LEN.
REQ-025 match_count shall increment by 1 on each match edge and saturate at 16'hFFFF.
REQ-026 cnt_clr=1 shall set match_count to 0, with priority over a simultaneous match.
REQ-027 cfg_load shall not affect match_count.

Reset
REQ-028 rst=1 shall immediately force: hist=0, fill=0, Y=0, match_count=0, pattern=RESET_PATTERN, len=RESET_LEN, overlap=RESET_OVERLAP.
REQ-029 Reset asserted mid-sequence shall discard partial history; detection resumes from an empty window on the first edge after deassertion.

Configuration
REQ-030 Macro PATTERN_DETECTOR_MATCH_COUNT_EN defined: match_count and cnt_clr shall behave per REQ-025..REQ-027.
REQ-031 Macro PATTERN_DETECTOR_MATCH_COUNT_EN undefined: the counter shall not be built, match_count shall be tied to 16'h0000, and cnt_clr shall be ignored; ports are unchanged.

Structure
REQ-032 Package pattern_detector_pkg shall hold the default MAX_LEN, RESET_LEN, RESET_PATTERN and RESET_OVERLAP constants, the counter width (16) and the saturation value.
REQ-033 Sub-module pattern_window shall contain hist, the fill counter and the masked compare, and produce the match strobe.
REQ-034 The top level shall hold the configuration registers, Y and match_count.

Verification
REQ-035 Reset defaults (len 2, pattern 01, overlap): A stream 0,1,0,0,1 all valid -> Y pulses in the cycles after the 2nd and 5th bits; match_count=2.
REQ-036 Load len 3, pattern 101, overlap=1; stream 1,0,1,0,1 -> 2 Y pulses; reload with overlap=0 and the same stream -> 1 pulse.
REQ-037 Pattern 01: bits 0 and 1 separated by 3 cycles of in_valid=0 -> 1 match; Y=0 during the gap cycles.
REQ-038 Assert rst after bit 0 of "01" and resend only 1 -> no match; send 0,1 -> match.
REQ-039 With the macro defined, preset the counter to 16'hFFFE via matches then 3 more matches -> match_count=16'hFFFF; cnt_clr together with a match -> 0.
REQ-040 cfg_len=0 with cfg_pattern=1 -> every valid 1 produces a Y pulse; cfg_len=12 with MAX_LEN=8 -> behaves as len 8.

Source files
------------

// File: rtl/pattern_detector_pkg.sv
// -----------------------------------------------------------------------------
// pattern_detector_pkg
//
// Purpose : shared constants for the serial pattern detector: default
//           parameter values, match-counter width and its saturation value,
//           and a helper that derives the pattern-length field width.
//
// Used by : pattern_window, pattern_detector (import pattern_detector_pkg::*)
// -----------------------------------------------------------------------------
package pattern_detector_pkg;

    // Default maximum pattern length in bits (legal range 2..16).
    localparam int DEF_MAX_LEN       = 8;

    // Configuration loaded by reset: pattern "01", length 2, overlapping.
    localparam int DEF_RESET_LEN     = 2;
    localparam int DEF_RESET_PATTERN = 1;
    localparam bit DEF_RESET_OVERLAP = 1'b1;

    // Match counter width and the value it sticks at.
    localparam int unsigned        CNT_W   = 16;
    localparam logic [CNT_W-1:0]   CNT_SAT = 16'hFFFF;

    // Width needed to hold a length value in the range 0..max_len.
    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/pattern_window.sv
// -----------------------------------------------------------------------------
// pattern_window
//
// Purpose : serial shift window with a bit-fill counter and masked compare.
//           Produces a combinational match strobe for the edge currently
//           being presented (i.e. it compares the window as it will look
//           after this edge's shift).
//
// Ports
//   clk        in   1        rising-edge clock
//   rst        in   1        asynchronous active-high reset (clears window)
//   i_clear    in   1        clear window and fill; suppresses sampling
//   i_valid    in   1        shift i_bit into the window on this edge
//   i_bit      in   1        serial data bit
//   i_pattern  in   MAX_LEN  pattern, LSB = last-received bit
//   i_len      in   LW       active pattern length, expected 1..MAX_LEN
//   i_overlap  in   1        1 = overlapping matches, 0 = restart after match
//   o_match    out  1        match strobe for this edge (combinational)
// -----------------------------------------------------------------------------
module pattern_window
    import pattern_detector_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LW      = len_width(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic               i_valid,
    input  logic               i_bit,
    input  logic [MAX_LEN-1:0] i_pattern,
    input  logic [LW-1:0]      i_len,
    input  logic               i_overlap,
    output logic               o_match
);

    localparam logic [LW-1:0] FILL_MAX = LW'(MAX_LEN);

    logic [MAX_LEN-1:0] r_hist;
    logic [LW-1:0]      r_fill;

    logic [MAX_LEN-1:0] w_hist_nxt;
    logic [MAX_LEN-1:0] w_mask;
    logic [LW-1:0]      w_fill_nxt;
    logic               w_match;

    // Fill counts bits received since the last clear, sticking at MAX_LEN.
    function automatic logic [LW-1:0] fill_sat_inc(input logic [LW-1:0] f);
        return (f >= FILL_MAX) ? FILL_MAX : f + LW'(1);
    endfunction

    always_comb begin
        w_hist_nxt = {r_hist[MAX_LEN-2:0], i_bit};
        w_fill_nxt = fill_sat_inc(r_fill);
        w_mask     = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (LW'(i) < i_len);
        end
        // The fill check stops a match against stale zeros left in the
        // window after a clear or a non-overlapping restart.
        w_match = i_valid && !i_clear
                  && ((w_hist_nxt & w_mask) == (i_pattern & w_mask))
                  && (w_fill_nxt >= i_len);
    end

    // Window state: shifts on each sampled bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_clear) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_valid) begin
            r_hist <= w_hist_nxt;
            // Non-overlapping mode restarts the count so the next match
            // needs a full len fresh bits; the history itself is kept.
            r_fill <= (w_match && !i_overlap) ? '0 : w_fill_nxt;
        end
    end

    assign o_match = w_match;

endmodule

// File: rtl/pattern_detector.sv
// -----------------------------------------------------------------------------
// pattern_detector
//
// Purpose : serial bit-pattern detector with run-time configurable pattern,
//           length and overlap mode. Y is a registered one-cycle pulse after
//           each matching edge; match_count counts matches (saturating).
//
// Optional feature macro: PATTERN_DETECTOR_MATCH_COUNT_EN
//   defined   : 16-bit saturating match counter with synchronous clear
//   undefined : no counter is built, match_count reads 0, cnt_clr ignored
//
// Ports
//   clk          in   1        rising-edge clock
//   rst          in   1        asynchronous active-high reset
//   in_valid     in   1        sample A on this edge
//   A            in   1        serial data bit
//   cfg_load     in   1        load cfg_* on this edge (window cleared)
//   cfg_pattern  in   MAX_LEN  new pattern, LSB-aligned, bit 0 = last bit
//   cfg_len      in   LW       new length; 0 -> 1, >MAX_LEN -> MAX_LEN
//   cfg_overlap  in   1        1 = overlapping, 0 = non-overlapping
//   cnt_clr      in   1        synchronous clear of match_count
//   Y            out  1        registered match pulse
//   match_count  out  16       number of matches
// -----------------------------------------------------------------------------
module pattern_detector
    import pattern_detector_pkg::*;
#(
    parameter int                 MAX_LEN       = DEF_MAX_LEN,
    parameter int                 RESET_LEN     = DEF_RESET_LEN,
    parameter logic [MAX_LEN-1:0] RESET_PATTERN = MAX_LEN'(DEF_RESET_PATTERN),
    parameter bit                 RESET_OVERLAP = DEF_RESET_OVERLAP,
    localparam int                LW            = len_width(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               A,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LW-1:0]      cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               Y,
    output logic [CNT_W-1:0]   match_count
);

    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

    logic [MAX_LEN-1:0] r_pattern;
    logic [LW-1:0]      r_len;
    logic               r_overlap;
    logic               r_y;
    logic               w_match;

    // Length 0 would mask everything and match on every bit regardless of
    // the pattern, so it is promoted to 1; oversized lengths are clamped.
    function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] len);
        if (len == '0) begin
            return LW'(1);
        end
        if (len > LEN_MAX) begin
            return LEN_MAX;
        end
        return len;
    endfunction

    // Configuration registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pattern <= RESET_PATTERN;
            r_len     <= clamp_len(LW'(RESET_LEN));
            r_overlap <= RESET_OVERLAP;
        end else if (cfg_load) begin
            r_pattern <= cfg_pattern;
            r_len     <= clamp_len(cfg_len);
            r_overlap <= cfg_overlap;
        end
    end

    // A load edge clears the window and blocks sampling of that edge's bit.
    pattern_window #(
        .MAX_LEN (MAX_LEN),
        .LW      (LW)
    ) u_window (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (cfg_load),
        .i_valid   (in_valid),
        .i_bit     (A),
        .i_pattern (r_pattern),
        .i_len     (r_len),
        .i_overlap (r_overlap),
        .o_match   (w_match)
    );

    // Output pulse register: follows the match strobe one cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y <= 1'b0;
        end else begin
            r_y <= w_match;
        end
    end

    assign Y = r_y;

`ifdef PATTERN_DETECTOR_MATCH_COUNT_EN
    logic [CNT_W-1:0] r_count;

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_SAT) ? CNT_SAT : c + CNT_W'(1);
    endfunction

    // Match counter: clear wins over a same-edge match; cfg_load leaves it alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (cnt_clr) begin
            r_count <= '0;
        end else if (w_match) begin
            r_count <= cnt_sat_inc(r_count);
        end
    end

    assign match_count = r_count;
`else
    logic w_unused_cnt_clr;
    assign w_unused_cnt_clr = cnt_clr;
    assign match_count      = '0;
`endif

endmodule

// File: tb/tb_pattern_detector.sv
module tb_pattern_detector;

    localparam int MAX_LEN = 8;
    localparam int LW      = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               A;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LW-1:0]      cfg_len;
    logic               cfg_overlap;
    logic               cnt_clr;
    logic               Y;
    logic [15:0]        match_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: bits received since the last clear (or since the last
    // match in non-overlapping mode); a match is the newest len bits equal
    // to the pattern's low len bits.
    int m_pat;
    int m_len;
    bit m_ovl;
    bit seg[$];
    bit m_y;
    int m_cnt;

    pattern_detector #(.MAX_LEN(MAX_LEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .A           (A),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cnt_clr     (cnt_clr),
        .Y           (Y),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] exp_cnt();
`ifdef PATTERN_DETECTOR_MATCH_COUNT_EN
        return 16'(m_cnt);
`else
        return 16'h0000;
`endif
    endfunction

    task automatic model_reset();
        seg.delete();
        m_pat = 1;
        m_len = 2;
        m_ovl = 1'b1;
        m_y   = 1'b0;
        m_cnt = 0;
    endtask

    task automatic model_edge();
        bit hit;
        hit = 1'b0;
        if (cfg_load) begin
            m_pat = int'(cfg_pattern);
            if (cfg_len == 0)            m_len = 1;
            else if (cfg_len > MAX_LEN)  m_len = MAX_LEN;
            else                         m_len = int'(cfg_len);
            m_ovl = cfg_overlap;
            seg.delete();
        end else if (in_valid) begin
            seg.push_back(A);
            if (seg.size() >= m_len) begin
                hit = 1'b1;
                for (int k = 0; k < m_len; k++) begin
                    if (seg[seg.size() - 1 - k] != bit'((m_pat >> k) & 1)) hit = 1'b0;
                end
            end
            if (hit && !m_ovl) seg.delete();
            while (seg.size() > MAX_LEN) void'(seg.pop_front());
        end
        m_y = hit;
        if (cnt_clr) m_cnt = 0;
        else if (hit && m_cnt < 65535) m_cnt++;
    endtask

    // One clock edge with the given data; one-shot controls are dropped after.
    task automatic tick(input bit v, input bit a);
        in_valid = v;
        A        = a;
        @(posedge clk);
        model_edge();
        #1;
        in_valid = 1'b0;
        cfg_load = 1'b0;
        cnt_clr  = 1'b0;
    endtask

    task automatic load_cfg(input int pat, input int len, input bit ovl);
        cfg_pattern = MAX_LEN'(pat);
        cfg_len     = LW'(len);
        cfg_overlap = ovl;
        cfg_load    = 1'b1;
        tick(1'b1, 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 0; A = 0; cfg_load = 0; cfg_pattern = 0; cfg_len = 0;
        cfg_overlap = 0; cnt_clr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (Y !== 1'b0) begin
            n_errors++; $display("FAIL reset_y: got %0b expected 0", Y);
        end
        n_checks++;
        if (match_count !== 16'h0) begin
            n_errors++; $display("FAIL reset_cnt: got %0h expected 0", match_count);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_defaults();
        bit stream [5] = '{0, 1, 0, 0, 1};
        bit exp_y  [5] = '{0, 1, 0, 0, 1};
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, stream[i]);
            n_checks++;
            if (Y !== exp_y[i]) begin
                n_errors++; $display("FAIL defaults_y[%0d]: got %0b expected %0b", i, Y, exp_y[i]);
            end
        end
        n_checks++;
`ifdef PATTERN_DETECTOR_MATCH_COUNT_EN
        if (match_count !== 16'd2) begin
            n_errors++; $display("FAIL defaults_cnt: got %0d expected 2", match_count);
        end
`else
        if (match_count !== 16'd0) begin
            n_errors++; $display("FAIL defaults_cnt: got %0d expected 0", match_count);
        end
`endif
    endtask

    task automatic test_overlap_modes();
        bit stream [5] = '{1, 0, 1, 0, 1};
        int pulses;
        for (int mode = 1; mode >= 0; mode--) begin
            load_cfg('b101, 3, bit'(mode));
            n_checks++;
            if (Y !== 1'b0) begin
                n_errors++; $display("FAIL load_clears_y: got %0b expected 0", Y);
            end
            pulses = 0;
            for (int i = 0; i < 5; i++) begin
                tick(1'b1, stream[i]);
                if (Y === 1'b1) pulses++;
                n_checks++;
                if (Y !== m_y) begin
                    n_errors++; $display("FAIL overlap%0d_y[%0d]: got %0b expected %0b", mode, i, Y, m_y);
                end
            end
            n_checks++;
            if (pulses != (mode ? 2 : 1)) begin
                n_errors++; $display("FAIL overlap%0d_pulses: got %0d expected %0d", mode, pulses, mode ? 2 : 1);
            end
        end
    endtask

    task automatic test_gap();
        load_cfg('b01, 2, 1'b1);
        tick(1'b1, 1'b0);
        for (int g = 0; g < 3; g++) begin
            tick(1'b0, 1'($urandom_range(0, 1)));
            n_checks++;
            if (Y !== 1'b0) begin
                n_errors++; $display("FAIL gap_y[%0d]: got %0b expected 0", g, Y);
            end
        end
        tick(1'b1, 1'b1);
        n_checks++;
        if (Y !== 1'b1) begin
            n_errors++; $display("FAIL gap_match: got %0b expected 1", Y);
        end
        tick(1'b0, 1'b1);
        n_checks++;
        if (Y !== 1'b0) begin
            n_errors++; $display("FAIL gap_pulse_width: got %0b expected 0", Y);
        end
    endtask

    task automatic test_reset_mid();
        load_cfg('b01, 2, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        #1 rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (Y !== 1'b0 || match_count !== 16'h0) begin
            n_errors++; $display("FAIL async_reset: got Y=%0b cnt=%0h expected 0/0", Y, match_count);
        end
        #1 rst = 1'b0;
        tick(1'b1, 1'b1);
        n_checks++;
        if (Y !== 1'b0) begin
            n_errors++; $display("FAIL reset_discard: got %0b expected 0", Y);
        end
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        n_checks++;
        if (Y !== 1'b1) begin
            n_errors++; $display("FAIL reset_resume: got %0b expected 1", Y);
        end
    endtask

    task automatic test_len_clamp();
        bit v, a;
        logic [7:0] pat;
        load_cfg(1, 0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            v = 1'($urandom_range(0, 1));
            a = 1'($urandom_range(0, 1));
            tick(v, a);
            n_checks++;
            if (Y !== (v & a)) begin
                n_errors++; $display("FAIL len0_y[%0d]: got %0b expected %0b", i, Y, v & a);
            end
        end
        pat = 8'hA5;
        load_cfg(int'(pat), 12, 1'b1);
        for (int i = 7; i >= 0; i--) begin
            tick(1'b1, pat[i]);
            n_checks++;
            if (Y !== (i == 0)) begin
                n_errors++; $display("FAIL len12_y[%0d]: got %0b expected %0b", i, Y, i == 0);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) begin
                cfg_load    = 1'b1;
                cfg_pattern = MAX_LEN'($urandom);
                cfg_len     = ($urandom_range(0, 3) == 0) ? LW'($urandom_range(0, 15))
                                                          : LW'($urandom_range(1, 4));
                cfg_overlap = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 49) == 0) cnt_clr = 1'b1;
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1;
                model_reset();
                #2 rst = 1'b0;
            end
            tick($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
            n_checks++;
            if (Y !== m_y) begin
                n_errors++; $display("FAIL random_y[%0d]: got %0b expected %0b", c, Y, m_y);
            end
            n_checks++;
            if (match_count !== exp_cnt()) begin
                n_errors++; $display("FAIL random_cnt[%0d]: got %0h expected %0h", c, match_count, exp_cnt());
            end
        end
    endtask

    task automatic test_saturation();
        logic [15:0] e;
        load_cfg(1, 1, 1'b1);
        cnt_clr = 1'b1;
        tick(1'b0, 1'b0);
        for (int i = 0; i < 65534; i++) tick(1'b1, 1'b1);
`ifdef PATTERN_DETECTOR_MATCH_COUNT_EN
        e = 16'hFFFE;
`else
        e = 16'h0000;
`endif
        n_checks++;
        if (match_count !== e) begin
            n_errors++; $display("FAIL sat_preset: got %0h expected %0h", match_count, e);
        end
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
`ifdef PATTERN_DETECTOR_MATCH_COUNT_EN
        e = 16'hFFFF;
`endif
        n_checks++;
        if (match_count !== e) begin
            n_errors++; $display("FAIL sat_hold: got %0h expected %0h", match_count, e);
        end
        cnt_clr = 1'b1;
        tick(1'b1, 1'b1);
        n_checks++;
        if (Y !== 1'b1 || match_count !== 16'h0) begin
            n_errors++; $display("FAIL clr_priority: got Y=%0b cnt=%0h expected 1/0", Y, match_count);
        end
        load_cfg('b11, 2, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
`ifdef PATTERN_DETECTOR_MATCH_COUNT_EN
        e = 16'h0001;
`endif
        n_checks++;
        if (match_count !== e) begin
            n_errors++; $display("FAIL load_keeps_cnt: got %0h expected %0h", match_count, e);
        end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_overlap_modes();
        test_gap();
        test_reset_mid();
        test_len_clamp();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
